gcd_stream: RTL and testbench
=============================

Name: gcd_stream

Overview:
- Parametrised iterative binary (Stein) GCD engine with valid/ready handshakes on both the input and the result.
- Each cycle it strips up to MAX_SHIFT trailing zeros, so even-heavy operands finish in fewer cycles.
- It reports the number of compute cycles taken, for each result.
- It sits behind a command FIFO or CSR front-end in the arithmetic-accelerator datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- MAX_SHIFT, 4, maximum number of trailing zeros removed per cycle (1..WIDTH-1). A value of 1 gives classic one-bit-per-cycle Stein behaviour.
- CNT_W, 8, width of the cycle counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  block can accept an operand pair
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- res_o  out  WIDTH  gcd(A,B)
- cycles_o  out  CNT_W  number of TRIM+COMPUTE cycles used for res_o, saturating
- abort_i  in  1  only present when GCD_ABORT_EN is defined

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_ni). While reset is asserted:
  - state=IDLE.
  - a_q, b_q, shift_q, res_q and cnt_q are all 0.
  - in_ready_o=1, out_valid_o=0, res_o=0, cycles_o=0.
- Reset mid-operation discards the operation; no result is produced.
- States: IDLE, TRIM, COMPUTE, DONE.
- ctz(x) is the trailing-zero count of x. k(x)=min(ctz(x),MAX_SHIFT).
- IDLE:
  - in_ready_o=1 here and only here.
  - On in_valid_i: load a_q=a_i, b_q=b_i, shift_q=0, cnt_q=0, then go to TRIM.
- TRIM (cnt_q increments each cycle, saturating at 2^CNT_W-1):
  - If a_q==0 or b_q==0: res_q=a_q|b_q, go to DONE. This gives gcd(0,x)=x and gcd(0,0)=0.
  - Else if k(a_q|b_q)>0: shift a_q and b_q right by k, shift_q+=k, stay in TRIM.
  - Else go to COMPUTE.
- COMPUTE (cnt_q increments each cycle, saturating), priority order:
  1. a_q even: a_q>>=k(a_q).
  2. b_q even: b_q>>=k(b_q).
  3. a_q==b_q: res_q=a_q<<shift_q, go to DONE.
  4. a_q>b_q: a_q=(a_q-b_q)>>1.
  5. Else: b_q=(b_q-a_q)>>1.
- Width rules:
  - shift_q is $clog2(WIDTH) bits; its maximum reachable value is WIDTH-1.
  - The result never overflows WIDTH because gcd<=min(A,B).
  - Subtraction is unsigned WIDTH-bit and is never negative, because it is guarded by the compare.
- DONE:
  - out_valid_o=1. res_o=res_q and cycles_o=cnt_q, both held stable while out_ready_i=0.
  - On out_ready_i: go to IDLE. No new input is accepted in the same cycle.
- res_o and cycles_o keep their last values in IDLE.
- Latency: input acceptance to out_valid_o is cnt_q+1 cycles. Throughput is at most one operation per cycles_o+2 cycles.
- in_valid_i outside IDLE is ignored. The source must hold a_i/b_i with in_valid_i until in_ready_o is seen.

Optional Feature:
- Macro GCD_ABORT_EN.
- Defined:
  - Port abort_i exists.
  - abort_i=1 in TRIM or COMPUTE forces the state to IDLE on the next edge. out_valid_o is not asserted, and res_o/cycles_o keep their previous values.
  - abort_i is ignored in IDLE and DONE.
- Not defined: no abort_i port; every accepted operation runs to DONE.

Test Plan:
- A=48, B=18, MAX_SHIFT=4 -> res_o=6, cycles_o=5, out_valid_o one cycle after the fifth compute cycle.
- A=0, B=20 -> res_o=20, cycles_o=1. A=0, B=0 -> res_o=0, cycles_o=1.
- A=B=2^31, WIDTH=32 -> res_o=0x8000_0000, cycles_o=10 (8 TRIM shift cycles: 4×7 then 3).
- A=1071, B=462 with out_ready_i low for 3 cycles after out_valid_o:
  - res_o=21 held stable throughout, in_ready_o=0 throughout.
  - Accepted on the 4th cycle, then in_ready_o=1.
- Reset pulse (rst_ni=0) during COMPUTE of A=1000, B=375:
  - Outputs zero immediately, with no result.
  - A following A=12, B=8 gives res_o=4.
- GCD_ABORT_EN: abort_i during COMPUTE of A=1071, B=462:
  - Next cycle IDLE, out_valid_o never asserted.
  - Next op A=7, B=5 -> res_o=1.

Source files
------------

// File: rtl/gcd_stream_if.sv
// +------------------------------------------------------------------+
// | Module : gcd_stream_if                                           |
// | Brief  : Operand/result handshake bundle for gcd_stream.         |
// |          Carries abort_i only when GCD_ABORT_EN is defined.      |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface gcd_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] res_o;
    logic [CNT_W-1:0] cycles_o;
`ifdef GCD_ABORT_EN
    logic             abort_i;

    modport master (
        output in_valid_i, a_i, b_i, out_ready_i, abort_i,
        input  in_ready_o, out_valid_o, res_o, cycles_o
    );
    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i, abort_i,
        output in_ready_o, out_valid_o, res_o, cycles_o
    );
`else
    modport master (
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, cycles_o
    );
    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, cycles_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/gcd_stream.sv
// +------------------------------------------------------------------+
// | Module : gcd_stream                                              |
// | Brief  : Iterative binary (Stein) GCD, up to MAX_SHIFT trailing  |
// |          zeros stripped per cycle. Optional macro: GCD_ABORT_EN. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module gcd_stream #(
    parameter int WIDTH     = 32,
    parameter int MAX_SHIFT = 4,
    parameter int CNT_W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    gcd_stream_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TRIM    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [SH_W-1:0]  k_ab, k_a, k_b;

    // min(ctz(x), MAX_SHIFT); x is never zero where the result is used
    function automatic logic [SH_W-1:0] trim_k(input logic [WIDTH-1:0] x);
        logic [SH_W-1:0] k;
        k = SH_W'(MAX_SHIFT);
        for (int i = MAX_SHIFT - 1; i >= 0; i--) begin
            if (x[i]) k = SH_W'(i);
        end
        return k;
    endfunction

    assign k_ab    = trim_k(a_q | b_q);
    assign k_a     = trim_k(a_q);
    assign k_b     = trim_k(b_q);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = S_TRIM;
                end
            end
            S_TRIM: begin
                cnt_d = cnt_inc;
                if (a_q == '0 || b_q == '0) begin
                    res_d   = a_q | b_q;
                    cyc_d   = cnt_inc;
                    state_d = S_DONE;
                end else if (k_ab != '0) begin
                    a_d     = a_q >> k_ab;
                    b_d     = b_q >> k_ab;
                    shift_d = shift_q + k_ab;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_inc;
                if (!a_q[0]) begin
                    a_d = a_q >> k_a;
                end else if (!b_q[0]) begin
                    b_d = b_q >> k_b;
                end else if (a_q == b_q) begin
                    res_d   = a_q << shift_q;
                    cyc_d   = cnt_inc;
                    state_d = S_DONE;
                end else if (a_q > b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef GCD_ABORT_EN
        // Abort wins over a completion in the same cycle; outputs keep the old result
        if (bus.abort_i && (state_q == S_TRIM || state_q == S_COMPUTE)) begin
            state_d = S_IDLE;
            res_d   = res_q;
            cyc_d   = cyc_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cyc_q   <= cyc_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.res_o       = res_q;
    assign bus.cycles_o    = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_stream.sv
// +------------------------------------------------------------------+
// | Module : tb_gcd_stream                                           |
// | Brief  : Directed self-checking bench for gcd_stream.            |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gcd_stream;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    gcd_stream_if #(.WIDTH(32), .CNT_W(8)) bus ();

    gcd_stream #(.WIDTH(32), .MAX_SHIFT(4), .CNT_W(8)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_idle", {63'd0, bus.in_ready_o}, 64'd1);
        bus.a_i        = a;
        bus.b_i        = b;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid_o && n < 300) begin
            tick();
            n++;
        end
        if (!bus.out_valid_o) begin
            errors++;
            checks++;
            $display("FAIL timeout: got out_valid=0 expected 1 within 300 cycles");
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input int ec);
        int n;
        start_op(a, b);
        wait_valid(n);
        chk("latency", 64'(n), 64'(ec));
        chk("res", 64'(bus.res_o), 64'(er));
        chk("cycles", 64'(bus.cycles_o), 64'(ec));
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("out_valid_drop", {63'd0, bus.out_valid_o}, 64'd0);
        chk("res_hold_idle", 64'(bus.res_o), 64'(er));
    endtask

    initial begin
        int  n;
        logic seen;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.out_ready_i = 1'b0;
`ifdef GCD_ABORT_EN
        bus.abort_i     = 1'b0;
`endif

        vecs[0] = '{a: 32'd48,         b: 32'd18,         res: 32'd6,          cyc: 5};
        vecs[1] = '{a: 32'd0,          b: 32'd20,         res: 32'd20,         cyc: 1};
        vecs[2] = '{a: 32'd0,          b: 32'd0,          res: 32'd0,          cyc: 1};
        vecs[3] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  res: 32'h8000_0000,  cyc: 10};
        vecs[4] = '{a: 32'd20,         b: 32'd0,          res: 32'd20,         cyc: 1};
        vecs[5] = '{a: 32'd9,          b: 32'd6,          res: 32'd3,          cyc: 4};
        vecs[6] = '{a: 32'd64,         b: 32'd48,         res: 32'd16,         cyc: 5};
        vecs[7] = '{a: 32'd17,         b: 32'd5,          res: 32'd1,          cyc: 6};
        vecs[8] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'hFFFF_FFFF,  cyc: 2};

        tick();
        tick();
        chk("rst_in_ready", {63'd0, bus.in_ready_o}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
        chk("rst_res", 64'(bus.res_o), 64'd0);
        chk("rst_cycles", 64'(bus.cycles_o), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cyc);
        end

        // Back-pressure: result held for three cycles, accepted on the fourth
        start_op(32'd1071, 32'd462);
        wait_valid(n);
        chk("bp_cycles", 64'(bus.cycles_o), 64'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid_held", {63'd0, bus.out_valid_o}, 64'd1);
            chk("bp_res_held", 64'(bus.res_o), 64'd21);
            chk("bp_in_ready_low", {63'd0, bus.in_ready_o}, 64'd0);
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("bp_in_ready_after", {63'd0, bus.in_ready_o}, 64'd1);
        chk("bp_valid_after", {63'd0, bus.out_valid_o}, 64'd0);

        // Asynchronous reset in the middle of COMPUTE
        start_op(32'd1000, 32'd375);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_res", 64'(bus.res_o), 64'd0);
        chk("arst_cycles", 64'(bus.cycles_o), 64'd0);
        chk("arst_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
        chk("arst_in_ready", {63'd0, bus.in_ready_o}, 64'd1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid_o) seen = 1'b1;
        end
        chk("arst_no_result", {63'd0, seen}, 64'd0);
        run_op(32'd12, 32'd8, 32'd4, 5);

`ifdef GCD_ABORT_EN
        start_op(32'd1071, 32'd462);
        tick();
        tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        chk("abort_idle", {63'd0, bus.in_ready_o}, 64'd1);
        chk("abort_res_kept", 64'(bus.res_o), 64'd4);
        chk("abort_cycles_kept", 64'(bus.cycles_o), 64'd5);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid_o) seen = 1'b1;
            tick();
        end
        chk("abort_no_valid", {63'd0, seen}, 64'd0);
        run_op(32'd7, 32'd5, 32'd1, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
